// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises an LFSR to the received stream while hunting,
// then free-runs it once locked and counts mismatched bits against the prediction.
module prbs_checker #(
    parameter int                    STATE_BITS  = 4,
    parameter logic [STATE_BITS-1:0] POLYNOMIAL  = 4'b1100,
    parameter int                    OUTPUT_BITS = 2,
    parameter int                    LOCK_COUNT  = 4,
    parameter int                    LOSS_COUNT  = 3,
    parameter int                    ERR_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic [OUTPUT_BITS-1:0] data,
    input  logic                   clear,
    output logic                   locked,
    output logic                   err_pulse,
    output logic [ERR_BITS-1:0]    err_count
);

    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(LOSS_COUNT + 1);
    localparam int PW = $clog2(OUTPUT_BITS + 1);
    // Sum is wide enough that err_count + popcount can never wrap before the saturation test.
    localparam int SW = ((ERR_BITS > PW) ? ERR_BITS : PW) + 1;

    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_COUNT);
    localparam logic [BW-1:0] LOSS_LIM = BW'(LOSS_COUNT);
    localparam logic [SW-1:0] ERR_MAX  = {{(SW-ERR_BITS){1'b0}}, {ERR_BITS{1'b1}}};

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [STATE_BITS-1:0] state_q, state_d;
    logic [CW-1:0]         clean_cnt_q, clean_cnt_d;
    logic [BW-1:0]         bad_cnt_q, bad_cnt_d;
    logic [ERR_BITS-1:0]   err_count_q, err_count_d;
    logic                  err_pulse_q, err_pulse_d;

    logic [STATE_BITS-1:0] st;
    logic [OUTPUT_BITS-1:0] mism;
    logic [PW-1:0]         pop;
    logic                  nb;
    logic                  fb;
    logic [SW-1:0]         sum;
    logic [ERR_BITS-1:0]   err_sat;

    // Step the LFSR once per stream bit, comparing each predicted bit with the received one.
    always_comb begin
        st   = state_q;
        mism = '0;
        pop  = '0;
        nb   = 1'b0;
        fb   = 1'b0;
        for (int i = 0; i < OUTPUT_BITS; i++) begin
            nb      = ^(st & POLYNOMIAL);
            mism[i] = nb ^ data[i];
            pop     = pop + PW'(nb ^ data[i]);
            // Hunting feeds the received bit back so the state tracks the line.
            fb      = (fsm_q == LOCKED) ? nb : data[i];
            st      = {st[STATE_BITS-2:0], fb};
        end
    end

    // Saturating accumulation of this beat's mismatches.
    always_comb begin
        sum     = SW'(err_count_q) + SW'(pop);
        err_sat = (sum > ERR_MAX) ? ERR_MAX[ERR_BITS-1:0] : sum[ERR_BITS-1:0];
    end

    // Next-state logic for the hunt/lock FSM, beat counters and error outputs.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        clean_cnt_d = clean_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        if (valid) begin
            state_d = st;
            if (fsm_q == HUNT) begin
                // A zero state predicts zeros forever, so it never counts as clean.
                if (mism == '0 && state_q != '0) begin
                    if (clean_cnt_q + CW'(1) == LOCK_LIM) begin
                        fsm_d       = LOCKED;
                        clean_cnt_d = '0;
                        bad_cnt_d   = '0;
                    end else begin
                        clean_cnt_d = clean_cnt_q + CW'(1);
                    end
                end else begin
                    clean_cnt_d = '0;
                end
            end else begin
                if (mism != '0) begin
                    err_pulse_d = 1'b1;
                    err_count_d = err_sat;
                    if (bad_cnt_q + BW'(1) == LOSS_LIM) begin
                        fsm_d       = HUNT;
                        bad_cnt_d   = '0;
                        clean_cnt_d = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + BW'(1);
                    end
                end else begin
                    bad_cnt_d = '0;
                end
            end
        end
        // Clear wins over any increment on the same beat.
        if (clear) begin
            err_count_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= HUNT;
            state_q     <= '0;
            clean_cnt_q <= '0;
            bad_cnt_q   <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            clean_cnt_q <= clean_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (fsm_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: table of beats with hand-derived expectations,
// plus sequences for asynchronous reset, a stuck line and counter saturation.
module tb_prbs_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, clear;
    logic [1:0] data;
    logic       locked, err_pulse;
    logic [7:0] err_count;

    logic       valid2, clear2;
    logic [1:0] data2;
    logic       locked2, err_pulse2;
    logic [1:0] err_count2;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .data      (data),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    prbs_checker #(.ERR_BITS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid2),
        .data      (data2),
        .clear     (clear2),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_count (err_count2)
    );

    typedef struct {
        logic       v;
        logic [1:0] flip;
        logic       clr;
        logic       el;
        logic       ep;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl [0:63];
    int   n_vec = 0;
    int   tests = 0;
    int   fails = 0;
    int   pos   = 0;
    // Bit i of the period-15 stream 001101011110001 is seq[i].
    logic [14:0] seq = 15'b100011110101100;

    task automatic add(input logic v, input logic [1:0] flip, input logic clr,
                       input logic el, input logic ep, input logic [7:0] ec);
        tbl[n_vec].v    = v;
        tbl[n_vec].flip = flip;
        tbl[n_vec].clr  = clr;
        tbl[n_vec].el   = el;
        tbl[n_vec].ep   = ep;
        tbl[n_vec].ec   = ec;
        n_vec++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    function automatic logic [1:0] next_beat();
        logic [1:0] d;
        d   = {seq[(pos + 1) % 15], seq[pos % 15]};
        pos = (pos + 2) % 15;
        return d;
    endfunction

    initial begin
        // Lock acquisition: beats 0,1 start from zero state, beats 2..5 clean -> lock after beat 5.
        for (int i = 0; i < 5; i++) add(1, 2'b00, 0, 0, 0, 0);
        add(1, 2'b00, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 2'b00, 0, 1, 0, 0);
        // Both bits flipped in one beat.
        add(1, 2'b11, 0, 1, 1, 2);
        add(1, 2'b00, 0, 1, 0, 2);
        add(1, 2'b00, 1, 1, 0, 0);
        // Three consecutive single-bit errors drop lock.
        add(1, 2'b01, 0, 1, 1, 1);
        add(1, 2'b01, 0, 1, 1, 2);
        add(1, 2'b01, 0, 0, 1, 3);
        // Re-lock from a correctly tracked state takes four clean beats.
        add(1, 2'b00, 0, 0, 0, 3);
        add(1, 2'b00, 0, 0, 0, 3);
        add(1, 2'b00, 0, 0, 0, 3);
        add(1, 2'b00, 0, 1, 0, 3);
        // Valid gap with garbage on data.
        for (int i = 0; i < 5; i++) add(0, 2'b11, 0, 1, 0, 3);
        add(1, 2'b00, 0, 1, 0, 3);
        add(1, 2'b00, 0, 1, 0, 3);
        add(1, 2'b10, 0, 1, 1, 4);
        add(0, 2'b00, 0, 1, 0, 4);
        add(1, 2'b00, 0, 1, 0, 4);
        add(1, 2'b11, 0, 1, 1, 6);

        rst_n = 1'b0; valid = 1'b0; data = 2'b00; clear = 1'b0;
        valid2 = 1'b0; data2 = 2'b00; clear2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset locked", locked, 0);
        chk("reset err_pulse", err_pulse, 0);
        chk("reset err_count", err_count, 0);
        chk("reset dut2 err_count", err_count2, 0);
        rst_n = 1'b1;

        for (int i = 0; i < n_vec; i++) begin
            valid = tbl[i].v;
            clear = tbl[i].clr;
            if (tbl[i].v) data = next_beat() ^ tbl[i].flip;
            else          data = tbl[i].flip;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d locked", i), locked, int'(tbl[i].el));
            chk($sformatf("vec%0d err_pulse", i), err_pulse, int'(tbl[i].ep));
            chk($sformatf("vec%0d err_count", i), err_count, int'(tbl[i].ec));
        end
        valid = 1'b0; clear = 1'b0;

        // Asynchronous reset mid-cycle while locked with err_pulse high.
        #2 rst_n = 1'b0;
        #1;
        chk("async rst locked", locked, 0);
        chk("async rst err_pulse", err_pulse, 0);
        chk("async rst err_count", err_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Stuck-at-zero line never locks and never counts.
        for (int i = 0; i < 50; i++) begin
            valid = 1'b1; data = 2'b00;
            @(posedge clk);
            #1;
            chk($sformatf("stuck%0d locked", i), locked, 0);
            chk($sformatf("stuck%0d err_count", i), err_count, 0);
        end
        valid = 1'b0;

        // Saturation on the 2-bit counter instance.
        pos = 0;
        for (int i = 0; i < 8; i++) begin
            valid2 = 1'b1; data2 = next_beat();
            @(posedge clk);
            #1;
        end
        chk("sat locked", locked2, 1);
        begin
            logic [1:0] flips [0:6];
            logic       clrs  [0:6];
            int         expc  [0:6];
            flips = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
            clrs  = '{0, 0, 0, 0, 0, 0, 1};
            expc  = '{1, 1, 2, 2, 3, 3, 0};
            for (int i = 0; i < 7; i++) begin
                data2 = next_beat() ^ flips[i];
                clear2 = clrs[i];
                @(posedge clk);
                #1;
                chk($sformatf("sat%0d err_count", i), err_count2, expc[i]);
                if (i == 0) chk("sat0 err_pulse", err_pulse2, 1);
            end
        end
        valid2 = 1'b0; clear2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
